classify_ctrl: RTL and testbench

CLASSIFY_CTRL -- requirements
Module: classify_ctrl

---
 rtl/classify_ctrl.sv | 142 ++++++++++++++
 tb/tb_classify_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/classify_ctrl.sv
// Sequences NUM_ROWS multiplier row operations, stores each row result and
// tracks the signed argmax, with a per-row watchdog and sticky overflow status.
module classify_ctrl #(
    parameter int NUM_ROWS = 10,
    parameter int TIMEOUT  = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        mult_begin,
    output logic [3:0]  mult_row_select,
    input  logic        done_row,
    input  logic [31:0] row_result,
    input  logic        overflow,
    output logic        res_we,
    output logic [3:0]  res_addr,
    output logic [31:0] res_data,
    output logic        busy,
    output logic        done,
    output logic [3:0]  class_id,
    output logic [31:0] class_score,
    output logic        ovf_flag,
    output logic        timeout
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    // The watchdog reads 0 in the first WAIT cycle, so this value puts FINISH
    // exactly TIMEOUT cycles after the mult_begin pulse.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 2);
    localparam logic [3:0]      ROW_LAST = 4'(NUM_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_STORE,
        S_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        row_q, row_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [31:0]       result_q, result_d;
    logic              ovf_cap_q, ovf_cap_d;
    logic              ovf_q, ovf_d;
    logic              tmo_q, tmo_d;
    logic [3:0]        cid_q, cid_d;
    logic [31:0]       cs_q, cs_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            wd_q      <= '0;
            result_q  <= '0;
            ovf_cap_q <= 1'b0;
            ovf_q     <= 1'b0;
            tmo_q     <= 1'b0;
            cid_q     <= '0;
            cs_q      <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            wd_q      <= wd_d;
            result_q  <= result_d;
            ovf_cap_q <= ovf_cap_d;
            ovf_q     <= ovf_d;
            tmo_q     <= tmo_d;
            cid_q     <= cid_d;
            cs_q      <= cs_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        wd_d      = wd_q;
        result_d  = result_q;
        ovf_cap_d = ovf_cap_q;
        ovf_d     = ovf_q;
        tmo_d     = tmo_q;
        cid_d     = cid_q;
        cs_d      = cs_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    row_d   = '0;
                    ovf_d   = 1'b0;
                    tmo_d   = 1'b0;
                    cid_d   = '0;
                    cs_d    = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done_row) begin
                    result_d  = row_result;
                    ovf_cap_d = overflow;
                    state_d   = S_STORE;
                end else if (wd_q == WD_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_STORE: begin
                ovf_d = ovf_q | ovf_cap_q;
                // Strict compare: on a tie the earlier (lower) row is kept.
                if (row_q == 4'd0 || $signed(result_q) > $signed(cs_q)) begin
                    cid_d = row_q;
                    cs_d  = result_q;
                end
                if (row_q == ROW_LAST) begin
                    state_d = S_FINISH;
                end else begin
                    row_d   = row_q + 4'd1;
                    state_d = S_ISSUE;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign mult_begin      = (state_q == S_ISSUE);
    assign mult_row_select = row_q;
    assign res_we          = (state_q == S_STORE);
    assign res_addr        = row_q;
    assign res_data        = result_q;
    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_FINISH);
    assign class_id        = cid_q;
    assign class_score     = cs_q;
    assign ovf_flag        = ovf_q;
    assign timeout         = tmo_q;

endmodule

// File: tb/tb_classify_ctrl.sv
// Randomized bench: a schedule-based reference builds the expected output
// timeline per cycle from the row timings, and a negedge process compares it.
module tb_classify_ctrl;

    localparam int N    = 10;
    localparam int TMO  = 1023;
    localparam int MAXC = 12000;

    logic        clk = 1'b0;
    logic        rst, start, done_row, overflow;
    logic [31:0] row_result;
    logic        mult_begin, res_we, busy, done, ovf_flag, timeout;
    logic [3:0]  mult_row_select, res_addr, class_id;
    logic [31:0] res_data, class_score;

    always #5 clk = ~clk;

    classify_ctrl #(.NUM_ROWS(N), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mult_begin(mult_begin), .mult_row_select(mult_row_select),
        .done_row(done_row), .row_result(row_result), .overflow(overflow),
        .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
        .busy(busy), .done(done), .class_id(class_id), .class_score(class_score),
        .ovf_flag(ovf_flag), .timeout(timeout)
    );

    // stimulus per cycle
    bit          st_a[MAXC], dr_a[MAXC], ov_a[MAXC], rs_a[MAXC], in_wait[MAXC];
    logic [31:0] rv_a[MAXC];
    // expected per cycle
    bit          e_busy[MAXC], e_mb[MAXC], e_we[MAXC], e_done[MAXC], e_zero[MAXC];
    int          e_row[MAXC];
    logic [3:0]  e_wa[MAXC];
    logic [31:0] e_wd[MAXC];
    bit          u_v[MAXC], u_ovf[MAXC], u_tmo[MAXC];
    logic [3:0]  u_cid[MAXC];
    logic [31:0] u_cs[MAXC];

    logic [31:0] p_val[N];
    int          p_dly[N];
    bit          p_ovf[N];
    int          last_b;

    int total = 0, bad = 0;
    int cyc = 0, last_c = 0;
    int n_we = 0, n_done = 0, n_mb = 0;
    int scen_end[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic set_stat(input int c, input logic [3:0] cid, input logic [31:0] cs,
                            input bit o, input bit t);
        u_v[c] = 1; u_cid[c] = cid; u_cs[c] = cs; u_ovf[c] = o; u_tmo[c] = t;
    endtask

    // Row r: issued at b, answered at b+dly (0 = never), stored the cycle after.
    task automatic plan(input int s, output int endc);
        int c, b, w;
        logic [3:0]  bid;
        logic [31:0] bv;
        bit          ov;
        st_a[s] = 1;
        set_stat(s + 1, 4'd0, 32'd0, 1'b0, 1'b0);
        bid = 0; bv = 0; ov = 0; c = s + 1;
        for (int r = 0; r < N; r++) begin
            b = c; last_b = b;
            e_busy[b] = 1; e_mb[b] = 1; e_row[b] = r;
            if (p_dly[r] == 0) begin
                for (int k = 1; k < TMO; k++) begin
                    e_busy[b+k] = 1; e_row[b+k] = r; in_wait[b+k] = 1;
                end
                c = b + TMO;
                set_stat(c, bid, bv, ov, 1'b1);
                e_busy[c] = 1; e_done[c] = 1;
                endc = c + 1;
                return;
            end
            w = b + p_dly[r];
            for (int k = 1; k <= p_dly[r]; k++) begin
                e_busy[b+k] = 1; e_row[b+k] = r; in_wait[b+k] = 1;
            end
            dr_a[w] = 1; rv_a[w] = p_val[r]; ov_a[w] = p_ovf[r];
            e_busy[w+1] = 1; e_we[w+1] = 1; e_wa[w+1] = 4'(r); e_wd[w+1] = p_val[r];
            e_row[w+1] = r;
            ov = ov | p_ovf[r];
            if (r == 0 || $signed(p_val[r]) > $signed(bv)) begin
                bid = 4'(r); bv = p_val[r];
            end
            set_stat(w + 2, bid, bv, ov, 1'b0);
            c = w + 2;
        end
        e_busy[c] = 1; e_done[c] = 1;
        endc = c + 1;
    endtask

    // Reset at cycle x (with a simultaneous start) cancels the rest of the plan.
    task automatic abort(input int x, input int endc);
        rs_a[x] = 1; st_a[x] = 1;
        for (int c = x + 1; c < endc; c++) begin
            e_busy[c] = 0; e_mb[c] = 0; e_we[c] = 0; e_done[c] = 0; e_row[c] = -1;
            in_wait[c] = 0; u_v[c] = 0; dr_a[c] = 0;
        end
        set_stat(x + 1, 4'd0, 32'd0, 1'b0, 1'b0);
        e_zero[x+1] = 1;
    endtask

    task automatic apply(input int c);
        rst = rs_a[c]; start = st_a[c]; done_row = dr_a[c];
        row_result = rv_a[c]; overflow = ov_a[c];
    endtask

    task automatic scen_check(input int k);
        case (k)
            0: begin
                chk("s1_we_cnt", n_we, 10); chk("s1_done_cnt", n_done, 1);
                chk("s1_cid", class_id, 0); chk("s1_cs", class_score, 784);
                chk("s1_ovf", ovf_flag, 0);
            end
            1: begin chk("s2_cid", class_id, 7); chk("s2_cs", class_score, 20776); end
            2: begin chk("s3_cid", class_id, 0); chk("s3_cs", class_score, 32'hFFFF_FFFB); end
            3: begin
                chk("s4_ovf", ovf_flag, 1); chk("s4_we_cnt", n_we, 10);
                chk("s4_done_cnt", n_done, 1);
            end
            4: begin
                chk("s5_tmo", timeout, 1); chk("s5_we_cnt", n_we, 2);
                chk("s5_done_cnt", n_done, 1);
            end
            default: begin
                chk("s6_done_cnt", n_done, 0); chk("s6_mb_cnt", n_mb, 6);
                chk("s6_busy", busy, 0);
            end
        endcase
        n_we = 0; n_done = 0; n_mb = 0;
    endtask

    // per-cycle comparison against the planned timeline
    logic [3:0]  x_cid = 0;
    logic [31:0] x_cs = 0;
    bit          x_ovf = 0, x_tmo = 0;
    always @(negedge clk) begin
        if (cyc >= 1 && cyc <= last_c) begin
            if (u_v[cyc]) begin
                x_cid = u_cid[cyc]; x_cs = u_cs[cyc]; x_ovf = u_ovf[cyc]; x_tmo = u_tmo[cyc];
            end
            chk("busy", busy, e_busy[cyc]);
            chk("mult_begin", mult_begin, e_mb[cyc]);
            chk("res_we", res_we, e_we[cyc]);
            chk("done", done, e_done[cyc]);
            chk("class_id", class_id, x_cid);
            chk("class_score", class_score, x_cs);
            chk("ovf_flag", ovf_flag, x_ovf);
            chk("timeout", timeout, x_tmo);
            if (e_row[cyc] >= 0) chk("row_sel", mult_row_select, 32'(e_row[cyc]));
            if (e_we[cyc]) begin
                chk("res_addr", res_addr, e_wa[cyc]);
                chk("res_data", res_data, e_wd[cyc]);
            end
            if (e_zero[cyc]) begin
                chk("rst_row_sel", mult_row_select, 0);
                chk("rst_res_addr", res_addr, 0);
                chk("rst_res_data", res_data, 0);
            end
            n_we   += int'(res_we);
            n_done += int'(done);
            n_mb   += int'(mult_begin);
        end
    end

    initial begin
        int c, e, k;
        for (int i = 0; i < MAXC; i++) begin e_row[i] = -1; rv_a[i] = 0; end
        for (int i = 0; i < 3; i++) rs_a[i] = 1;
        set_stat(1, 4'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) e_zero[i] = 1;
        c = 5;
        // all rows equal, slow multiplier
        for (int r = 0; r < N; r++) begin p_val[r] = 784; p_dly[r] = 400; p_ovf[r] = 0; end
        plan(c, e); scen_end[0] = e; c = e + 2;
        // peak on row 7
        for (int r = 0; r < N; r++) begin
            p_val[r] = (r == 7) ? 32'd20776 : 32'(r * 100);
            p_dly[r] = $urandom_range(1, 8); p_ovf[r] = 0;
        end
        plan(c, e); scen_end[1] = e; c = e;
        // all negative: signed compare
        for (int r = 0; r < N; r++) begin p_val[r] = 32'(-(r + 5)); p_dly[r] = $urandom_range(1, 8); end
        plan(c, e); scen_end[2] = e; c = e + 1;
        // overflow on row 3 only
        for (int r = 0; r < N; r++) begin
            p_val[r] = $urandom; p_dly[r] = $urandom_range(1, 8); p_ovf[r] = (r == 3);
        end
        plan(c, e); scen_end[3] = e; c = e + 3;
        // row 2 never answers
        for (int r = 0; r < N; r++) begin p_dly[r] = (r == 2) ? 0 : 5; p_ovf[r] = 0; end
        plan(c, e); scen_end[4] = e; c = e + 2;
        // reset in the WAIT of row 5
        for (int r = 0; r < N; r++) p_dly[r] = (r == 5) ? 0 : 3;
        plan(c, e);
        abort(last_b + 50, e); scen_end[5] = last_b + 51; c = last_b + 53;
        // random classifications, some back-to-back, some with tie-prone values
        for (int t = 0; t < 6; t++) begin
            for (int r = 0; r < N; r++) begin
                p_val[r] = (t % 2 == 0) ? $urandom : 32'(int'($urandom_range(0, 6)) - 3);
                p_dly[r] = $urandom_range(1, 12);
                p_ovf[r] = ($urandom_range(0, 4) == 0);
            end
            plan(c, e); c = e + ((t % 3 == 0) ? 0 : int'($urandom_range(1, 3)));
        end
        last_c = c + 4;
        // stray done_row outside WAIT and starts while busy must be ignored
        for (int i = 4; i < last_c; i++) begin
            if (!in_wait[i] && !dr_a[i] && $urandom_range(0, 3) == 0) begin
                dr_a[i] = 1; rv_a[i] = $urandom; ov_a[i] = $urandom_range(0, 1);
            end
            if (e_busy[i] && !st_a[i] && !rs_a[i] && $urandom_range(0, 7) == 0) st_a[i] = 1;
        end

        k = 0;
        apply(0);
        while (cyc < last_c) begin
            @(posedge clk);
            #1;
            cyc++;
            if (k < 6 && cyc == scen_end[k]) begin scen_check(k); k++; end
            apply(cyc);
        end
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
